line_window_buf: RTL
====================

// Module: line_window_buf
// PURPOSE
//  Parametrised raster line buffer and 3x3 window generator for the convolution datapath.
//  Accepts one pixel per handshake in raster order and keeps two full image lines in circular RAMs.
//  Emits one zero-padded 3x3 neighbourhood per image pixel, so a frame yields exactly IMG_W*IMG_H windows.
//  Sits between the pixel source and the 3x3 MAC stage.
// PARAMETERS
//  DATA_W  9    pixel width in bits
//  IMG_W   180  pixels per line (>=2)
//  IMG_H   180  lines per frame (>=2)
// PORTS
//  clk          in   1          single clock, all logic on posedge
//  reset        in   1          asynchronous, active-high
//  pushpixel    in   1          input valid; pixel accepted when pushpixel && in_ready at posedge clk
//  din          in   DATA_W     input pixel
//  in_ready     out  1          block can accept a pixel this cycle
//  win          out  9*DATA_W   window; win[k*DATA_W +: DATA_W], k=0 top-left .. 4 centre .. 8 bottom-right, row-major
//  win_valid    out  1          win/center_* valid for exactly this cycle
//  center_row   out  $clog2(IMG_H)  image row of window centre
//  center_col   out  $clog2(IMG_W)  image column of window centre
//  frame_done   out  1          one-cycle pulse, same cycle as the last window of the frame
// BEHAVIOUR
//  Reset: state=FILL, row/col counters=0, in_ready=1, win=0, win_valid=0, center_*=0, frame_done=0; RAM contents not cleared.
//  Slot: any cycle that accepts a pixel, or any internally generated PADCOL/FLUSH cycle. Each slot:
//   col counter c selects RAM address; new window column = {lb1[c], lb0[c], x}, x=din (or 0 in PADCOL/FLUSH);
//   lb1[c]<=lb0[c], lb0[c]<=x; window shifts left one column.
//   Slot (r,c) produces centre (r-1, c-1); PADCOL slot c=IMG_W.
//  Latency: win/win_valid registered, valid on the cycle after the producing slot.
//  Suppression: win_valid=0 for any slot with centre row -1 or centre col -1.
//  Masking: when centre_row==0, top window row forced to 0; when centre_col==0, left column forced to 0.
//   Stale RAM data from a previous frame never appears in win.
//  States:
//   FILL   row 0 accepted, no outputs; after pixel (0,IMG_W-1) -> PADCOL.
//   RUN    rows 1..IMG_H-1; after pixel c=IMG_W-1 -> PADCOL.
//   PADCOL 1 cycle, in_ready=0, x=0, emits centre (r-1,IMG_W-1); then r++, c=0;
//          next state is RUN, or FLUSH if the completed row was IMG_H-1.
//   FLUSH  IMG_W+1 cycles, in_ready=0, x=0 (virtual row IMG_H), emits last image row;
//          frame_done with final window; -> FILL, counters=0.
//  in_ready = (state==FILL || state==RUN); pushpixel while in_ready=0 is ignored (pixel dropped).
//  Idle (no pushpixel in FILL/RUN): state, window and outputs hold; win_valid=0.
//  Reset mid-frame: immediate abort; next accepted pixel is (0,0) of a new frame.
//  Widths: no arithmetic on pixel data; counters wrap only via explicit state transitions.
// STRUCTURE
//  Shared header conv_pkg.vh: DATA_W/IMG_W/IMG_H defaults, window index localparams WIN_TL..WIN_BR (0..8),
//   state encodings ST_FILL/ST_RUN/ST_PADCOL/ST_FLUSH.
//  Sub-module line_ram (DEPTH=IMG_W, WIDTH=DATA_W): async read, sync write, same address; instantiated twice (lb0, lb1).
//  Top: FSM, row/col counters, 3x3 register window, masking mux, output registers.
// TESTING (IMG_W=4, IMG_H=3, DATA_W=9, din=1..12 in raster order unless stated)
//  1 Full frame, pushpixel every cycle -> exactly 12 win_valid pulses, centres in raster order (0,0)..(2,3);
//    in_ready low 1 cycle after each row, 5 cycles at end; frame_done only with centre (2,3).
//  2 Window content -> centre (0,0): {0,0,0, 0,1,2, 0,5,6}; centre (1,1): {1,2,3, 5,6,7, 9,10,11};
//    centre (2,3): {7,8,0, 11,12,0, 0,0,0}.
//  3 Gapped input, pushpixel toggling 1/0 -> same 12 windows, identical to test 2; win_valid never 1 twice for one centre.
//  4 pushpixel held high through PADCOL/FLUSH, din=99 on those cycles -> 99 never appears in any win;
//    window values identical to test 2.
//  5 Reset asserted after pixel 6, then clean frame 101..112 -> no win_valid before the new frame's row 1;
//    centre (0,0) = {0,0,0, 0,101,102, 0,105,106}.
//  6 Back-to-back frames 1..12 then 201..212 -> second frame centre (0,1) top row all 0
//    (no stale 9..12); 24 windows, 2 frame_done pulses.

Source files
------------

// File: rtl/line_window_buf_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : line_window_buf_pkg
//  Description : Shared defaults, 3x3 window tap indices and FSM state
//                encoding for the raster line buffer / window generator.
//  Revision    : 1.0  initial release
// ============================================================================
package line_window_buf_pkg;

    // Default geometry of the convolution datapath
    localparam int DEF_DATA_W = 9;
    localparam int DEF_IMG_W  = 180;
    localparam int DEF_IMG_H  = 180;

    // Window tap indices, row-major, top-left first
    localparam int WIN_TL    = 0;
    localparam int WIN_TM    = 1;
    localparam int WIN_TR    = 2;
    localparam int WIN_ML    = 3;
    localparam int WIN_MC    = 4;
    localparam int WIN_MR    = 5;
    localparam int WIN_BL    = 6;
    localparam int WIN_BM    = 7;
    localparam int WIN_BR    = 8;
    localparam int WIN_TAPS  = 9;

    // Frame sequencing states
    typedef enum logic [1:0] {
        ST_FILL   = 2'd0,   // accepting row 0, nothing to emit yet
        ST_RUN    = 2'd1,   // accepting rows 1..IMG_H-1
        ST_PADCOL = 2'd2,   // one virtual right-pad column after each row
        ST_FLUSH  = 2'd3    // virtual bottom-pad row drains the last image row
    } lwb_state_t;

endpackage
`default_nettype wire

// File: rtl/line_window_buf_line_ram.sv
`default_nettype none
// ============================================================================
//  Module      : line_ram
//  Description : One image line of storage; asynchronous read, synchronous
//                write, single shared address.
//  Revision    : 1.0  initial release
// ============================================================================
module line_ram #(
    parameter int DEPTH = 180,
    parameter int WIDTH = 9
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    // Contents are never cleared; stale data is masked downstream
    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[addr] <= wdata;
        end
    end

    assign rdata = r_mem[addr];

endmodule
`default_nettype wire

// File: rtl/line_window_buf.sv
`default_nettype none
// ============================================================================
//  Module      : line_window_buf
//  Description : Raster line buffer producing one zero-padded 3x3 window per
//                image pixel. Two circular line RAMs hold the previous two
//                rows; a virtual pad column and pad row close each line/frame.
//  Revision    : 1.0  initial release
// ============================================================================
module line_window_buf
    import line_window_buf_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int IMG_W  = DEF_IMG_W,
    parameter int IMG_H  = DEF_IMG_H
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      pushpixel,
    input  logic [DATA_W-1:0]         din,
    output logic                      in_ready,
    output logic [9*DATA_W-1:0]       win,
    output logic                      win_valid,
    output logic [$clog2(IMG_H)-1:0]  center_row,
    output logic [$clog2(IMG_W)-1:0]  center_col,
    output logic                      frame_done
);

    // Counters reach IMG_H (virtual pad row) and IMG_W (pad column)
    localparam int c_row_w = $clog2(IMG_H + 1);
    localparam int c_col_w = $clog2(IMG_W + 1);
    localparam int c_adr_w = $clog2(IMG_W);
    localparam int c_orw   = $clog2(IMG_H);
    localparam int c_ocw   = $clog2(IMG_W);

    localparam logic [c_row_w-1:0] c_last_row = c_row_w'(IMG_H - 1);
    localparam logic [c_row_w-1:0] c_row_one  = c_row_w'(1);
    localparam logic [c_col_w-1:0] c_last_col = c_col_w'(IMG_W - 1);
    localparam logic [c_col_w-1:0] c_pad_col  = c_col_w'(IMG_W);
    localparam logic [c_col_w-1:0] c_col_one  = c_col_w'(1);

    lwb_state_t          r_state, w_state_nxt;
    logic [c_row_w-1:0]  r_row, w_row_nxt;
    logic [c_col_w-1:0]  r_col, w_col_nxt;

    logic                w_in_ready;
    logic                w_slot;
    logic                w_pad;
    logic                w_emit;
    logic                w_last;
    logic [DATA_W-1:0]   w_x;
    logic [DATA_W-1:0]   w_lb0_rd;
    logic [DATA_W-1:0]   w_lb1_rd;
    logic [DATA_W-1:0]   r_win     [WIN_TAPS];
    logic [DATA_W-1:0]   w_win_nxt [WIN_TAPS];
    logic [DATA_W-1:0]   w_win_msk [WIN_TAPS];

    assign w_in_ready = (r_state == ST_FILL) || (r_state == ST_RUN);
    assign in_ready   = w_in_ready;
    // PADCOL/FLUSH cycles are slots by themselves; input is ignored there
    assign w_slot     = w_in_ready ? pushpixel : 1'b1;
    assign w_pad      = (r_col == c_pad_col);
    assign w_x        = w_in_ready ? din : '0;
    // Slot (r,c) centres on (r-1,c-1); row 0 or column 0 slots have no centre
    assign w_emit     = w_slot && (r_row != '0) && (r_col != '0);
    assign w_last     = w_slot && (r_state == ST_FLUSH) && w_pad;

    line_ram #(
        .DEPTH (IMG_W),
        .WIDTH (DATA_W)
    ) u_lb0 (
        .clk   (clk),
        .we    (w_slot && !w_pad),
        .addr  (c_adr_w'(r_col)),
        .wdata (w_x),
        .rdata (w_lb0_rd)
    );

    line_ram #(
        .DEPTH (IMG_W),
        .WIDTH (DATA_W)
    ) u_lb1 (
        .clk   (clk),
        .we    (w_slot && !w_pad),
        .addr  (c_adr_w'(r_col)),
        .wdata (w_lb0_rd),
        .rdata (w_lb1_rd)
    );

    // State and raster counters
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_FILL;
            r_row   <= '0;
            r_col   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_row   <= w_row_nxt;
            r_col   <= w_col_nxt;
        end
    end

    // Next-state: rows end in a pad column, the frame ends in a pad row
    always_comb begin
        w_state_nxt = r_state;
        w_row_nxt   = r_row;
        w_col_nxt   = r_col;
        case (r_state)
            ST_FILL, ST_RUN: begin
                if (pushpixel) begin
                    if (r_col == c_last_col) begin
                        w_col_nxt   = c_pad_col;
                        w_state_nxt = ST_PADCOL;
                    end else begin
                        w_col_nxt   = r_col + c_col_one;
                    end
                end
            end
            ST_PADCOL: begin
                w_row_nxt   = r_row + c_row_one;
                w_col_nxt   = '0;
                w_state_nxt = (r_row == c_last_row) ? ST_FLUSH : ST_RUN;
            end
            ST_FLUSH: begin
                if (w_pad) begin
                    w_state_nxt = ST_FILL;
                    w_row_nxt   = '0;
                    w_col_nxt   = '0;
                end else begin
                    w_col_nxt   = r_col + c_col_one;
                end
            end
            default: begin
                w_state_nxt = ST_FILL;
                w_row_nxt   = '0;
                w_col_nxt   = '0;
            end
        endcase
    end

    // Shift window left and append the new column (zero in the pad column)
    always_comb begin
        w_win_nxt[WIN_TL] = r_win[WIN_TM];
        w_win_nxt[WIN_TM] = r_win[WIN_TR];
        w_win_nxt[WIN_TR] = w_pad ? '0 : w_lb1_rd;
        w_win_nxt[WIN_ML] = r_win[WIN_MC];
        w_win_nxt[WIN_MC] = r_win[WIN_MR];
        w_win_nxt[WIN_MR] = w_pad ? '0 : w_lb0_rd;
        w_win_nxt[WIN_BL] = r_win[WIN_BM];
        w_win_nxt[WIN_BM] = r_win[WIN_BR];
        w_win_nxt[WIN_BR] = w_pad ? '0 : w_x;
    end

    // Zero the top row / left column at image edges; hides stale RAM data
    always_comb begin
        w_win_msk = w_win_nxt;
        if (r_row == c_row_one) begin
            w_win_msk[WIN_TL] = '0;
            w_win_msk[WIN_TM] = '0;
            w_win_msk[WIN_TR] = '0;
        end
        if (r_col == c_col_one) begin
            w_win_msk[WIN_TL] = '0;
            w_win_msk[WIN_ML] = '0;
            w_win_msk[WIN_BL] = '0;
        end
    end

    // Window shift register advances once per slot
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < WIN_TAPS; k++) begin
                r_win[k] <= '0;
            end
        end else if (w_slot) begin
            r_win <= w_win_nxt;
        end
    end

    // Registered outputs; window/centre hold between emitted windows
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            win        <= '0;
            win_valid  <= 1'b0;
            center_row <= '0;
            center_col <= '0;
            frame_done <= 1'b0;
        end else begin
            win_valid  <= w_emit;
            frame_done <= w_last;
            if (w_emit) begin
                for (int k = 0; k < WIN_TAPS; k++) begin
                    win[k*DATA_W +: DATA_W] <= w_win_msk[k];
                end
                center_row <= c_orw'(r_row - c_row_one);
                center_col <= c_ocw'(r_col - c_col_one);
            end
        end
    end

endmodule
`default_nettype wire
